// File: rtl/inv_key_store_if.sv
// rtl/inv_key_store_if.sv - key load and round-key read bus of the inverse key-expansion store
interface inv_key_store_if #(
    parameter int AW = 4
);
    logic [127:0]  key_in;
    logic          key_valid;
    logic          key_ready;
    logic          flush;
    logic [AW-1:0] rd_addr;
    logic [127:0]  rd_data;
    logic          rd_valid;
    logic          busy;
    logic          keys_ready;

    modport master (
        output key_in, key_valid, flush, rd_addr,
        input  key_ready, rd_data, rd_valid, busy, keys_ready
    );

    modport slave (
        input  key_in, key_valid, flush, rd_addr,
        output key_ready, rd_data, rd_valid, busy, keys_ready
    );
endinterface

// File: rtl/inv_key_store.sv
// rtl/inv_key_store.sv - sequential inverse AES key schedule, one round per clock, into a readable round-key store
module inv_key_store #(
    parameter int         NUM_ROUNDS = 10,
    parameter logic [7:0] RCON_LAST  = 8'h36
) (
    input logic            clk,
    input logic            rst,
    inv_key_store_if.slave ks
);
    localparam int AW = $clog2(NUM_ROUNDS + 1);

    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b);
        logic [7:0] a;
        logic [7:0] p;
        a = a_in;
        p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1B) : {a[6:0], 1'b0};
        end
        return p;
    endfunction

    // S-box computed as x^254 (multiplicative inverse, 0 -> 0) followed by the affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] t;
        logic [7:0] inv;
        t   = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            t   = gf_mul(t, t);
            inv = gf_mul(inv, t);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] inv_key_sched(input logic [7:0] rc, input logic [127:0] k);
        logic [31:0] p1, p2, p3, t;
        p3 = k[31:0]  ^ k[63:32];
        p2 = k[63:32] ^ k[95:64];
        p1 = k[95:64] ^ k[127:96];
        t  = {sbox(p3[23:16]), sbox(p3[15:8]), sbox(p3[7:0]), sbox(p3[31:24])};
        return {k[127:96] ^ t ^ {rc, 24'h0}, p1, p2, p3};
    endfunction

    function automatic logic [7:0] inv_xtime(input logic [7:0] r);
        return r[0] ? ((r >> 1) ^ 8'h8D) : (r >> 1);
    endfunction

    state_t                state_q, state_d;
    logic [127:0]          work_q, work_d;
    logic [7:0]            rcon_q, rcon_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic [NUM_ROUNDS:0]   valid_q, valid_d;
    logic [127:0]          rd_data_q, rd_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [127:0]          store_q [0:NUM_ROUNDS];
    logic [127:0]          sched;
    logic                  we;
    logic [AW-1:0]         waddr;
    logic [127:0]          wdata;
    logic                  rd_in_range;

    assign sched = inv_key_sched(rcon_q, work_q);

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        rcon_d  = rcon_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        we      = 1'b0;
        waddr   = idx_q;
        wdata   = sched;
        if (ks.flush) begin
            valid_d = '0;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (ks.key_valid) begin
                        we                  = 1'b1;
                        waddr               = AW'(NUM_ROUNDS);
                        wdata               = ks.key_in;
                        valid_d             = '0;
                        valid_d[NUM_ROUNDS] = 1'b1;
                        work_d              = ks.key_in;
                        rcon_d              = RCON_LAST;
                        idx_d               = AW'(NUM_ROUNDS - 1);
                        state_d             = EXPAND;
                    end
                end
                EXPAND: begin
                    we             = 1'b1;
                    work_d         = sched;
                    valid_d[idx_q] = 1'b1;
                    rcon_d         = inv_xtime(rcon_q);
                    idx_d          = idx_q - 1'b1;
                    if (idx_q == '0) state_d = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Read path looks at next-state valid bits and the pending write so a same-edge write is visible.
    always_comb begin
        rd_in_range = int'(ks.rd_addr) <= NUM_ROUNDS;
        rd_data_d   = '0;
        rd_valid_d  = 1'b0;
        if (rd_in_range) begin
            rd_data_d  = (we && waddr == ks.rd_addr) ? wdata : store_q[ks.rd_addr];
            rd_valid_d = valid_d[ks.rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            work_q     <= '0;
            rcon_q     <= '0;
            idx_q      <= '0;
            valid_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            rcon_q     <= rcon_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (we) store_q[waddr] <= wdata;
    end

    assign ks.key_ready  = (state_q == IDLE) || (state_q == DONE);
    assign ks.busy       = (state_q == EXPAND);
    assign ks.keys_ready = (state_q == DONE);
    assign ks.rd_data    = rd_data_q;
    assign ks.rd_valid   = rd_valid_q;
endmodule
